store_demux: RTL

//  Bus bridge from the CPU data-memory port out to NDEV slaves (DM, timers, IO); the distributing counterpart of the read-data selectors.

---
 rtl/store_demux_pkg.sv | 22 ++
 rtl/store_demux_decode.sv | 28 ++
 rtl/store_demux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/store_demux_pkg.sv
// Shared types and constants for the store_demux bridge: FSM encoding,
// bus widths and the default slave address map.
package store_demux_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NDEV_DEF = 4;

    // Slot i holds slave i: DM at 0x0 (16 KiB), then three 16-byte peripheral windows.
    localparam logic [NDEV_DEF*ADDR_W-1:0] DEV_BASE_DEF =
        {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
    localparam logic [NDEV_DEF*ADDR_W-1:0] DEV_MASK_DEF =
        {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/store_demux_decode.sv
// Combinational address decoder: maps a byte address to {hit, one-hot select}.
// When windows overlap, the lowest-numbered slave wins.
module store_demux_decode
    import store_demux_pkg::*;
#(
    parameter int                         NDEV     = NDEV_DEF,
    parameter logic [NDEV*ADDR_W-1:0]     DEV_BASE = DEV_BASE_DEF,
    parameter logic [NDEV*ADDR_W-1:0]     DEV_MASK = DEV_MASK_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [NDEV-1:0]   sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Walk from the top so a lower-index match overrides a higher one.
        for (int i = NDEV - 1; i >= 0; i--) begin
            if ((addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_demux.sv
// Single-outstanding load/store bridge from the CPU data port to NDEV slaves.
// Optional BUSY watchdog enabled by defining STORE_DEMUX_TIMEOUT_EN.
module store_demux
    import store_demux_pkg::*;
#(
    parameter int                         NDEV           = NDEV_DEF,
    parameter logic [NDEV*ADDR_W-1:0]     DEV_BASE       = DEV_BASE_DEF,
    parameter logic [NDEV*ADDR_W-1:0]     DEV_MASK       = DEV_MASK_DEF,
    parameter int                         TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [3:0]             req_be,
    output logic [NDEV-1:0]        dev_valid,
    output logic                   dev_we,
    output logic [ADDR_W-1:0]      dev_addr,
    output logic [DATA_W-1:0]      dev_wdata,
    output logic [3:0]             dev_be,
    input  logic [NDEV-1:0]        dev_ready,
    input  logic [NDEV*DATA_W-1:0] dev_rdata,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [DATA_W-1:0]      resp_rdata
);

    state_t              state, state_n;
    logic                dec_hit;
    logic [NDEV-1:0]     dec_sel;
    logic [NDEV-1:0]     sel_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   sel_rdata;
    logic                done;
    logic                timeout;

    store_demux_decode #(
        .NDEV     (NDEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr (req_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Only the selected slave's ready counts; strays from other slaves are masked off.
    assign done = |(dev_ready & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef STORE_DEMUX_TIMEOUT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state != ST_BUSY) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign timeout = (state == ST_BUSY) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    logic [7:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
    assign timeout               = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (req_valid) state_n = dec_hit ? ST_BUSY : ST_ERR;
            ST_BUSY: begin
                if (done) begin
                    state_n = ST_RESP;
                end else if (timeout) begin
                    state_n = ST_ERR;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so dev_* stay stable through BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                sel_q   <= dec_sel;
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state == ST_BUSY && done) begin
                rdata_q <= we_q ? '0 : sel_rdata;
            end
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        dev_valid  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        unique case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_BUSY: dev_valid = sel_q;
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign dev_we    = we_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev_be    = be_q;

endmodule
